// File: rtl/icache_fetch_arbiter.sv
// rtl/icache_fetch_arbiter.sv - round-robin arbiter sharing one I-Cache fetch port between two IFUs
//
// Ports:
//   clk, reset_n                      core clock, asynchronous active-low reset
//   way0_* / way1_*                   IFU fetch request/address in, response pulse/instruction out
//   jumpFlag_i                        redirect: squashes the outstanding fetch
//   icache_request_o/instAddr_o       request and captured address towards the I-Cache
//   icache_dataOk_i/inst_i            I-Cache response
//   grantWay_o                        owner of the current or most recent grant
//   busy_o                            a fetch is outstanding (WAIT or DRAIN)
//   discardCount_o                    saturating count of squashed responses
module icache_fetch_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  way0_request_i,
    input  logic [ADDR_WIDTH-1:0] way0_instAddr_fetch_i,
    output logic                  way0_dataOk_o,
    output logic [INST_WIDTH-1:0] way0_inst_fetch_o,
    input  logic                  way1_request_i,
    input  logic [ADDR_WIDTH-1:0] way1_instAddr_fetch_i,
    output logic                  way1_dataOk_o,
    output logic [INST_WIDTH-1:0] way1_inst_fetch_o,
    input  logic                  jumpFlag_i,
    output logic                  icache_request_o,
    output logic [ADDR_WIDTH-1:0] icache_instAddr_o,
    input  logic                  icache_dataOk_i,
    input  logic [INST_WIDTH-1:0] icache_inst_i,
    output logic                  grantWay_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  discardCount_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ok0_q, ok0_d;
    logic                  ok1_q, ok1_d;
    logic [INST_WIDTH-1:0] inst0_q, inst0_d;
    logic [INST_WIDTH-1:0] inst1_q, inst1_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  disc_q, disc_d;
    // Way that wins when both request; starts on way0.
    logic                  prio_q, prio_d;

    logic                  cand0, cand1, winner;
    logic [CNT_WIDTH-1:0]  disc_inc;

    // A way whose response is being delivered this cycle still has its request
    // high (the IFU drops it only after seeing dataOk), so it is masked out.
    assign cand0  = way0_request_i & ~ok0_q;
    assign cand1  = way1_request_i & ~ok1_q;
    assign winner = (cand0 & cand1) ? prio_q : cand1;

    assign disc_inc = (&disc_q) ? disc_q : disc_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ok0_q   <= 1'b0;
            ok1_q   <= 1'b0;
            inst0_q <= '0;
            inst1_q <= '0;
            grant_q <= 1'b0;
            busy_q  <= 1'b0;
            disc_q  <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ok0_q   <= ok0_d;
            ok1_q   <= ok1_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            disc_q  <= disc_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ok0_d   = 1'b0;
        ok1_d   = 1'b0;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        grant_d = grant_q;
        disc_d  = disc_q;
        prio_d  = prio_q;

        case (state_q)
            IDLE: begin
                // Any cache response seen here belongs to an abandoned fetch.
                if (!jumpFlag_i && (cand0 || cand1)) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = winner ? way1_instAddr_fetch_i : way0_instAddr_fetch_i;
                    grant_d = winner;
                    prio_d  = ~winner;
                end
            end
            WAIT: begin
                if (icache_dataOk_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    if (jumpFlag_i) begin
                        disc_d = disc_inc;
                    end else if (grant_q) begin
                        ok1_d   = 1'b1;
                        inst1_d = icache_inst_i;
                    end else begin
                        ok0_d   = 1'b1;
                        inst0_d = icache_inst_i;
                    end
                end else if (jumpFlag_i) begin
                    // The cache cannot abort, so keep requesting and drop the answer.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (icache_dataOk_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    disc_d  = disc_inc;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign icache_request_o  = req_q;
    assign icache_instAddr_o = addr_q;
    assign way0_dataOk_o     = ok0_q;
    assign way1_dataOk_o     = ok1_q;
    assign way0_inst_fetch_o = inst0_q;
    assign way1_inst_fetch_o = inst1_q;
    assign grantWay_o        = grant_q;
    assign busy_o            = busy_q;
    assign discardCount_o    = disc_q;

endmodule

// File: doc/icache_fetch_arbiter.md
Name: icache_fetch_arbiter

Overview:
Shares the single I-Cache fetch port between the way0 and way1 instruction fetch units of the dual-issue front end. It grants one fetch at a time using round-robin priority, holds the granted address stable until the cache returns data, and routes the response back to the owning way. A jump squashes the in-flight fetch: the arbiter drains and discards it so no stale instruction reaches either IFU.

Parameters:
ADDR_WIDTH, 32, instruction fetch address width
INST_WIDTH, 32, fetched instruction width
CNT_WIDTH, 16, width of the saturating discarded-fetch counter

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
way0_request_i  in  1  way0 IFU fetch request; held until way0_dataOk_o
way0_instAddr_fetch_i  in  ADDR_WIDTH  way0 fetch address; stable while way0_request_i is high
way0_dataOk_o  out  1  one-cycle pulse: way0 response valid
way0_inst_fetch_o  out  INST_WIDTH  instruction for way0; valid when way0_dataOk_o is high
way1_request_i  in  1  way1 IFU fetch request
way1_instAddr_fetch_i  in  ADDR_WIDTH  way1 fetch address
way1_dataOk_o  out  1  one-cycle pulse: way1 response valid
way1_inst_fetch_o  out  INST_WIDTH  instruction for way1
jumpFlag_i  in  1  redirect; squashes the outstanding fetch
icache_request_o  out  1  request to I-Cache
icache_instAddr_o  out  ADDR_WIDTH  address to I-Cache
icache_dataOk_i  in  1  I-Cache response valid
icache_inst_i  in  INST_WIDTH  I-Cache response data
grantWay_o  out  1  owner of the current or most recent grant (0 = way0, 1 = way1)
busy_o  out  1  high in WAIT or DRAIN
discardCount_o  out  CNT_WIDTH  saturating count of squashed responses

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs are 0: icache_request_o, icache_instAddr_o, both dataOk_o, both inst_fetch_o, grantWay_o, busy_o, discardCount_o. Priority pointer favours way0. Asserting reset mid-fetch abandons the fetch immediately; the cache response that follows after reset is ignored while the arbiter is in IDLE.
- Only one fetch is outstanding at any time. All outputs are registered.
- IDLE:
  - If jumpFlag_i=1, no grant is made this cycle.
  - Otherwise, candidates are the ways with request_i=1, excluding any way whose dataOk_o is high this cycle (just-served mask).
  - One candidate: grant it. Two candidates: grant the way not granted last. On the first arbitration after reset, way0 wins.
  - On grant: next cycle the state is WAIT, icache_request_o=1, icache_instAddr_o=the granted way's address (captured), grantWay_o=the winner, and the priority pointer updates.
- WAIT:
  - icache_request_o and the captured address are held until icache_dataOk_i=1.
  - icache_dataOk_i=1 and jumpFlag_i=0: next cycle the owner's dataOk_o=1 for exactly one cycle with inst_fetch_o=icache_inst_i (captured). icache_request_o=0 and the state returns to IDLE.
  - icache_dataOk_i=1 and jumpFlag_i=1 in the same cycle: the response is discarded, no dataOk_o is produced, discardCount_o is incremented, and the state goes to IDLE.
  - jumpFlag_i=1 with no icache_dataOk_i: go to DRAIN. A request cannot be aborted at the cache, so icache_request_o stays high.
- DRAIN:
  - Wait for icache_dataOk_i. On it, discard the data, increment discardCount_o, drop icache_request_o, and return to IDLE.
  - jumpFlag_i has no further effect in DRAIN.
- Latency:
  - Request sampled in IDLE at cycle N gives icache_request_o at N+1.
  - Cache response at cycle M gives dataOk_o at M+1. The next grant is decided at M+1 and issued at M+2.
- inst_fetch_o of the non-owning way holds its last value. The IFU qualifies data only with dataOk_o.
- discardCount_o saturates at all-ones and never wraps.
- busy_o = (state != IDLE).

Test Plan:
- Single way0 request, address 0x8000_0000; cache responds 3 cycles after request with 0x0000_0013 -> icache_request_o high cycles 1-4; way0_dataOk_o is a single pulse one cycle after icache_dataOk_i with inst 0x0000_0013; way1_dataOk_o stays 0.
- Both ways request continuously (way0 0x100, way1 0x200), cache answers in 1 cycle -> grants alternate way0, way1, way0, way1; icache_instAddr_o alternates 0x100, 0x200; each way gets one dataOk_o per grant.
- jumpFlag_i pulsed 1 cycle after grant to way1; cache responds 4 cycles later -> state DRAIN, icache_request_o held until icache_dataOk_i, no dataOk_o on either way, discardCount_o = 1, then IDLE.
- jumpFlag_i in the same cycle as icache_dataOk_i in WAIT -> no dataOk_o, discardCount_o increments, next grant possible the following cycle. jumpFlag_i in IDLE with a pending request -> no grant that cycle; grant the cycle after.
- Assert reset_n=0 while in WAIT -> all outputs 0 asynchronously. A late icache_dataOk_i after release is ignored. The first subsequent dual request is granted to way0.
- Force 2^CNT_WIDTH+3 squashed fetches (CNT_WIDTH=4 build) -> discardCount_o saturates at 0xF.
